controle_alarme: RTL and testbench
==================================

CONTROLE_ALARME -- requirements
Module: controle_alarme

Interface
REQ-001 Parameter T_SAIDA, default 16: exit-delay length in CLK cycles; legal 1..255.
REQ-002 Parameter T_ENTRADA, default 8: entry-delay length in CLK cycles; legal 1..255.
REQ-003 Parameter T_SIRENE, default 32: siren duration in CLK cycles; legal 1..255.
REQ-004 Parameter SENHA, default 4'b1010: disarm code.
REQ-005 Parameter MAX_ERROS, default 3: consecutive wrong codes that force ALARME; legal 1..7.
REQ-006 CLK  input  1  single clock; all state changes on rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 ARM  input  1  arm request, sampled per cycle.
REQ-009 DISARM  input  1  disarm request, qualified by CODE in the same cycle.
REQ-010 CODE  input  4  code presented with DISARM.
REQ-011 Y  input  1  mode select: 1 perimeter (door/windows), 0 internal presence.
REQ-012 A  input  1  detection from the alarm datapath (already gated by ENABLE).
REQ-013 P  input  1  door sensor, raw.
REQ-014 ENABLE  output  1  enable to the alarm datapath.
REQ-015 MODO  output  1  Y latched at arming; drives datapath Y.
REQ-016 SIRENE  output  1  siren drive.
REQ-017 BIP  output  1  delay-warning beeper.
REQ-018 ESTADO  output  3  current state code.

Function
REQ-019 FSM states, encoded on ESTADO: DESARMADO=0, SAIDA=1, ARMADO=2, ENTRADA=3, ALARME=4; codes 5..7 unreachable and SHALL go to DESARMADO on the next edge.
REQ-020 Outputs SHALL be Moore/registered: ENABLE=1 in ARMADO, ENTRADA, ALARME; BIP=1 in SAIDA, ENTRADA; SIRENE=1 only in ALARME; else 0.
REQ-021 Correct code = DISARM=1 and CODE==SENHA; wrong code = DISARM=1 and CODE!=SENHA.
REQ-022 DESARMADO: ARM=1 -> SAIDA, MODO<=Y, 8-bit counter CONT<=T_SAIDA-1; DISARM ignored.
REQ-023 SAIDA: CONT decrements each cycle; CONT==0 -> ARMADO; correct code -> DESARMADO (priority over expiry).
REQ-024 ARMADO: correct code -> DESARMADO; else A=1 with P=1 and MODO=1 -> ENTRADA, CONT<=T_ENTRADA-1; else A=1 -> ALARME, CONT<=T_SIRENE-1.
REQ-025 ENTRADA: correct code -> DESARMADO; else A=1 with P=0 -> ALARME immediately; else CONT==0 -> ALARME; otherwise decrement.
REQ-026 ALARME: correct code -> DESARMADO; else CONT==0 -> ARMADO (rearm, error counter kept); otherwise decrement; A ignored.
REQ-027 Error counter ERROS (3 bits): increments on wrong code in SAIDA/ARMADO/ENTRADA/ALARME; saturates at MAX_ERROS; reaching MAX_ERROS outside ALARME -> ALARME next edge with CONT<=T_SIRENE-1.
REQ-028 ERROS SHALL clear on any transition into DESARMADO; wrong code in DESARMADO ignored.
REQ-029 ARM outside DESARMADO SHALL be ignored; ARM and DISARM in the same cycle: DISARM evaluated, ARM ignored.
REQ-030 MODO SHALL change only on DESARMADO->SAIDA; Y changes while armed have no effect.
REQ-031 Latency: request sampled at edge N, new state and outputs visible after edge N; a T-cycle delay occupies exactly T cycles in its state.

Reset
REQ-032 RST=1 SHALL immediately force ESTADO=DESARMADO, CONT=0, ERROS=0, MODO=0, ENABLE=0, SIRENE=0, BIP=0, regardless of CLK, including mid-delay or mid-ALARME.
REQ-033 After RST deasserts, first transition occurs on the next rising CLK edge with ARM=1.

Verification (T_SAIDA=4, T_ENTRADA=3, T_SIRENE=5, SENHA=1010, MAX_ERROS=3)
REQ-034 Arm, Y=1, ARM pulse -> SAIDA 4 cycles BIP=1 ENABLE=0, then ARMADO ENABLE=1 MODO=1.
REQ-035 ARMADO, MODO=1, A=1 P=1 -> ENTRADA 3 cycles; CODE=1010 DISARM in 2nd cycle -> DESARMADO, SIRENE never 1.
REQ-036 ARMADO, A=1 P=0 -> ALARME, SIRENE=1 exactly 5 cycles, then ARMADO; ENTRADA expiry likewise -> ALARME.
REQ-037 Three DISARM with CODE=0000 in ARMADO -> ALARME after third; then CODE=1010 -> DESARMADO, ERROS=0.
REQ-038 RST pulse mid-ALARME between clock edges -> SIRENE=0, ESTADO=0 immediately; ARM and DISARM same cycle in DESARMADO -> stays DESARMADO.

Source files
------------

// File: rtl/controle_alarme.sv
// controle_alarme: arming/disarming controller for a two-mode intrusion alarm.
//
// Ports
//   clk_i      single clock, all state changes on the rising edge
//   rst_i      asynchronous, active-high reset
//   arm_i      arm request (only honoured while disarmed)
//   disarm_i   disarm request, qualified by code_i in the same cycle
//   code_i     4-bit code presented with disarm_i
//   y_i        mode select: 1 perimeter (door/windows), 0 internal presence
//   a_i        detection from the alarm datapath (already gated by enable_o)
//   p_i        raw door sensor
//   enable_o   enable to the alarm datapath
//   modo_o     y_i latched at arming, drives the datapath mode
//   sirene_o   siren drive
//   bip_o      delay-warning beeper
//   estado_o   current state code
//
// state     | meaning
// ----------+--------------------------------------------------------
// DESARMADO | idle, waiting for arm_i
// SAIDA     | exit delay running, beeper on
// ARMADO    | armed, watching a_i
// ENTRADA   | entry delay after a door opening, beeper on
// ALARME    | siren on for T_SIRENE cycles, then rearm
module controle_alarme #(
  parameter int unsigned   T_SAIDA   = 16,
  parameter int unsigned   T_ENTRADA = 8,
  parameter int unsigned   T_SIRENE  = 32,
  parameter logic [3:0]    SENHA     = 4'b1010,
  parameter int unsigned   MAX_ERROS = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       arm_i,
  input  logic       disarm_i,
  input  logic [3:0] code_i,
  input  logic       y_i,
  input  logic       a_i,
  input  logic       p_i,
  output logic       enable_o,
  output logic       modo_o,
  output logic       sirene_o,
  output logic       bip_o,
  output logic [2:0] estado_o
);

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    ALARME    = 3'd4
  } estado_t;

  // Counters are loaded with T-1 so a delay spends exactly T cycles in its state.
  localparam logic [7:0] CONT_SAIDA   = 8'(T_SAIDA - 1);
  localparam logic [7:0] CONT_ENTRADA = 8'(T_ENTRADA - 1);
  localparam logic [7:0] CONT_SIRENE  = 8'(T_SIRENE - 1);
  localparam logic [2:0] ERROS_MAX    = 3'(MAX_ERROS);

  estado_t    state_q, state_d;
  logic [7:0] cont_q, cont_d;
  logic [2:0] erros_q, erros_d;
  logic       modo_q, modo_d;
  logic       enable_q, sirene_q, bip_q;

  logic       code_ok;
  logic       code_bad;
  logic [2:0] erros_inc;
  logic       erros_hit;
  logic       cont_zero;

  assign code_ok   = disarm_i && (code_i == SENHA);
  assign code_bad  = disarm_i && (code_i != SENHA);
  assign erros_inc = (erros_q >= ERROS_MAX) ? ERROS_MAX : erros_q + 3'd1;
  // A wrong code that lands on the limit forces the siren; a count already
  // saturated after a rearm only re-triggers on a further wrong code.
  assign erros_hit = code_bad && (erros_inc == ERROS_MAX);
  assign cont_zero = (cont_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    erros_d = erros_q;
    modo_d  = modo_q;

    case (state_q)
      DESARMADO: begin
        erros_d = 3'd0;
        // disarm_i in the same cycle wins and the arm request is dropped
        if (arm_i && !disarm_i) begin
          state_d = SAIDA;
          modo_d  = y_i;
          cont_d  = CONT_SAIDA;
        end
      end

      SAIDA, ARMADO, ENTRADA, ALARME: begin
        if (code_ok) begin
          state_d = DESARMADO;
          cont_d  = 8'd0;
          erros_d = 3'd0;
        end else begin
          if (code_bad) erros_d = erros_inc;

          if (erros_hit && (state_q != ALARME)) begin
            state_d = ALARME;
            cont_d  = CONT_SIRENE;
          end else begin
            case (state_q)
              SAIDA: begin
                if (cont_zero) state_d = ARMADO;
                else           cont_d  = cont_q - 8'd1;
              end
              ARMADO: begin
                if (a_i && p_i && modo_q) begin
                  state_d = ENTRADA;
                  cont_d  = CONT_ENTRADA;
                end else if (a_i) begin
                  state_d = ALARME;
                  cont_d  = CONT_SIRENE;
                end
              end
              ENTRADA: begin
                // detection without the door open is an intruder already inside
                if ((a_i && !p_i) || cont_zero) begin
                  state_d = ALARME;
                  cont_d  = CONT_SIRENE;
                end else begin
                  cont_d = cont_q - 8'd1;
                end
              end
              ALARME: begin
                if (cont_zero) state_d = ARMADO;
                else           cont_d  = cont_q - 8'd1;
              end
              default: state_d = DESARMADO;
            endcase
          end
        end
      end

      // unreachable codes recover to idle
      default: begin
        state_d = DESARMADO;
        cont_d  = 8'd0;
        erros_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= DESARMADO;
      cont_q   <= 8'd0;
      erros_q  <= 3'd0;
      modo_q   <= 1'b0;
      enable_q <= 1'b0;
      sirene_q <= 1'b0;
      bip_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      erros_q  <= erros_d;
      modo_q   <= modo_d;
      enable_q <= (state_d == ARMADO) || (state_d == ENTRADA) || (state_d == ALARME);
      sirene_q <= (state_d == ALARME);
      bip_q    <= (state_d == SAIDA) || (state_d == ENTRADA);
    end
  end

  assign estado_o = state_q;
  assign modo_o   = modo_q;
  assign enable_o = enable_q;
  assign sirene_o = sirene_q;
  assign bip_o    = bip_q;

endmodule

// File: tb/tb_controle_alarme.sv
module tb_controle_alarme;

  localparam int         T_S  = 4;
  localparam int         T_E  = 3;
  localparam int         T_A  = 5;
  localparam logic [3:0] PW   = 4'b1010;
  localparam int         MAXE = 3;

  localparam int S_DES = 0, S_SAI = 1, S_ARM = 2, S_ENT = 3, S_ALA = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arm = 1'b0, dis = 1'b0, y = 1'b0, a = 1'b0, p = 1'b0;
  logic [3:0] code = 4'd0;
  logic       enable, modo, sirene, bip;
  logic [2:0] estado;

  int vectors = 0;
  int miscompares = 0;

  controle_alarme #(
    .T_SAIDA(T_S), .T_ENTRADA(T_E), .T_SIRENE(T_A), .SENHA(PW), .MAX_ERROS(MAXE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .disarm_i(dis), .code_i(code),
    .y_i(y), .a_i(a), .p_i(p),
    .enable_o(enable), .modo_o(modo), .sirene_o(sirene), .bip_o(bip),
    .estado_o(estado)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Delays are tracked as absolute edge numbers at which the state expires.
  int m_st = S_DES, m_modo = 0, m_err = 0, m_dl = 0, m_cyc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = S_DES; m_modo = 0; m_err = 0;
    end else begin
      bit ok, bad;
      m_cyc++;
      ok  = dis && (code == PW);
      bad = dis && (code != PW);
      if (m_st == S_DES) begin
        m_err = 0;
        if (arm && !dis) begin
          m_st = S_SAI; m_modo = y; m_dl = m_cyc + T_S;
        end
      end else if (ok) begin
        m_st = S_DES; m_err = 0;
      end else begin
        if (bad) m_err = (m_err + 1 > MAXE) ? MAXE : m_err + 1;
        if (bad && m_err == MAXE && m_st != S_ALA) begin
          m_st = S_ALA; m_dl = m_cyc + T_A;
        end else if (m_st == S_SAI) begin
          if (m_cyc == m_dl) m_st = S_ARM;
        end else if (m_st == S_ARM) begin
          if (a && p && m_modo == 1) begin m_st = S_ENT; m_dl = m_cyc + T_E; end
          else if (a) begin m_st = S_ALA; m_dl = m_cyc + T_A; end
        end else if (m_st == S_ENT) begin
          if ((a && !p) || m_cyc == m_dl) begin m_st = S_ALA; m_dl = m_cyc + T_A; end
        end else if (m_st == S_ALA) begin
          if (m_cyc == m_dl) m_st = S_ARM;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("estado", estado, m_st);
    check("enable", enable, (m_st == S_ARM || m_st == S_ENT || m_st == S_ALA) ? 1 : 0);
    check("bip",    bip,    (m_st == S_SAI || m_st == S_ENT) ? 1 : 0);
    check("sirene", sirene, (m_st == S_ALA) ? 1 : 0);
    check("modo",   modo,   m_modo);
    check("erros",  dut.erros_q, m_err);
  end

  // ---------------- stimulus ----------------
  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit ar, input bit di, input logic [3:0] cd,
                       input bit yy, input bit aa, input bit pp);
    arm = ar; dis = di; code = cd; y = yy; a = aa; p = pp;
  endtask

  task automatic arm_seq(input bit yy);
    drive(1, 0, 0, yy, 0, 0);
    edge_wait();
    drive(0, 0, 0, yy, 0, 0);
    for (int i = 0; i < T_S; i++) edge_wait();
    check("armed", estado, S_ARM);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_estado", estado, 0);
    check("rst_enable", enable, 0);
    check("rst_modo", modo, 0);
    #9 rst = 1'b0;

    // exit delay, perimeter mode
    drive(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < T_S; i++) begin
      edge_wait();
      check("saida_estado", estado, 1);
      check("saida_bip", bip, 1);
      check("saida_enable", enable, 0);
      drive(0, 0, 0, 1, 0, 0);
    end
    edge_wait();
    check("armado_estado", estado, 2);
    check("armado_enable", enable, 1);
    check("armado_modo", modo, 1);

    // door opening, correct code in 2nd entry cycle
    drive(0, 0, 0, 0, 1, 1);
    edge_wait();
    check("entrada_estado", estado, 3);
    drive(0, 0, 0, 0, 0, 0);
    edge_wait();
    check("entrada_2nd", estado, 3);
    check("entrada_sirene", sirene, 0);
    drive(0, 1, PW, 0, 0, 0);
    edge_wait();
    check("disarm_estado", estado, 0);
    check("disarm_sirene", sirene, 0);
    drive(0, 0, 0, 0, 0, 0);

    // internal mode: detection goes straight to the siren for 5 cycles
    arm_seq(0);
    drive(0, 0, 0, 0, 1, 0);
    edge_wait();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < T_A; i++) begin
      check("siren_on", sirene, 1);
      edge_wait();
    end
    check("rearm_estado", estado, 2);
    check("rearm_sirene", sirene, 0);

    // entry-delay expiry
    drive(0, 1, PW, 0, 0, 0);
    edge_wait();
    arm_seq(1);
    drive(0, 0, 0, 1, 1, 1);
    edge_wait();
    drive(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < T_E - 1; i++) begin
      check("ent_hold", estado, 3);
      edge_wait();
    end
    check("ent_last", estado, 3);
    edge_wait();
    check("ent_expire", estado, 4);

    // three wrong codes while armed
    drive(0, 1, PW, 0, 0, 0);
    edge_wait();
    arm_seq(1);
    drive(0, 1, 4'b0000, 1, 0, 0);
    edge_wait();
    check("err1_estado", estado, 2);
    check("err1_count", dut.erros_q, 1);
    edge_wait();
    check("err2_estado", estado, 2);
    edge_wait();
    check("err3_estado", estado, 4);
    drive(0, 1, PW, 1, 0, 0);
    edge_wait();
    check("err_clear_estado", estado, 0);
    check("err_clear_count", dut.erros_q, 0);

    // async reset mid-alarm, then ARM+DISARM together
    arm_seq(0);
    drive(0, 0, 0, 0, 1, 0);
    edge_wait();
    drive(0, 0, 0, 0, 0, 0);
    check("pre_rst_sirene", sirene, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_sirene", sirene, 0);
    check("rst_mid_estado", estado, 0);
    rst = 1'b0;
    drive(1, 1, PW, 1, 0, 0);
    edge_wait();
    check("arm_dis_same", estado, 0);
    drive(0, 0, 0, 0, 0, 0);

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      edge_wait();
      drive(($urandom % 4) == 0, ($urandom % 7) == 0,
            ($urandom % 2) ? PW : 4'($urandom),
            1'($urandom), ($urandom % 6) == 0, 1'($urandom));
      if (($urandom % 250) == 0) begin
        #1 rst = 1'b1;
        #1;
        check("rnd_rst_estado", estado, 0);
        rst = 1'b0;
      end
    end

    edge_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
